// File: rtl/alu_share_arb_pkg.sv
// Shared encodings for the ALU sharing arbiter: alu_op values,
// the ops this arbiter forwards to the ALU, and FSM state codes.
package alu_share_arb_pkg;

    localparam logic [3:0] ALU_ADD = 4'h0;
    localparam logic [3:0] ALU_SUB = 4'h1;
    localparam logic [3:0] ALU_AND = 4'h2;
    localparam logic [3:0] ALU_OR  = 4'h3;
    localparam logic [3:0] ALU_XOR = 4'h4;

    // The minirv ALU implements only ADD; anything else would abort it.
    localparam int         N_LEGAL = 1;
    localparam logic [3:0] LEGAL_OPS [N_LEGAL] = '{ALU_ADD};

    typedef logic [1:0] state_t;

    localparam state_t IDLE  = 2'd0;
    localparam state_t ISSUE = 2'd1;
    localparam state_t RESP  = 2'd2;

    function automatic logic op_is_legal(input logic [3:0] op);
        logic hit;
        hit = 1'b0;
        for (int i = 0; i < N_LEGAL; i++) begin
            if (op == LEGAL_OPS[i]) begin
                hit = 1'b1;
            end
        end
        return hit;
    endfunction

endpackage

// File: rtl/alu_share_arb_rr_pick.sv
// Combinational round-robin picker: first set request after last,
// searching upward with wrap-around.
module alu_share_arb_rr_pick #(
    parameter int NREQ = 2,
    parameter int IDXW = 1
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDXW-1:0] last,
    output logic [NREQ-1:0] gnt,
    output logic [IDXW-1:0] idx,
    output logic            any
);

    always_comb begin
        int c;
        gnt = '0;
        idx = '0;
        any = 1'b0;
        c   = 0;
        for (int i = 1; i <= NREQ; i++) begin
            c = (int'(last) + i) % NREQ;
            if (!any && req[c]) begin
                any    = 1'b1;
                gnt[c] = 1'b1;
                idx    = IDXW'(c);
            end
        end
    end

endmodule

// File: rtl/alu_share_arb.sv
// Shares one combinational ALU between NREQ requesters with
// round-robin acceptance and a registered per-requester response.
module alu_share_arb
    import alu_share_arb_pkg::*;
#(
    parameter int NREQ = 2,
    parameter int XLEN = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NREQ-1:0]    req_valid,
    output logic [NREQ-1:0]    req_ready,
    input  logic [4*NREQ-1:0]  req_op,
    input  logic [XLEN*NREQ-1:0] req_a,
    input  logic [XLEN*NREQ-1:0] req_b,
    output logic [NREQ-1:0]    rsp_valid,
    input  logic [NREQ-1:0]    rsp_ready,
    output logic [XLEN-1:0]    rsp_data,
    output logic               rsp_err,
    output logic [3:0]         alu_op,
    output logic [XLEN-1:0]    alu_a,
    output logic [XLEN-1:0]    alu_b,
    input  logic [XLEN-1:0]    alu_result,
    output logic               busy
);

    localparam int IDXW = (NREQ > 1) ? $clog2(NREQ) : 1;

    state_t            state_q, state_d;
    logic [IDXW-1:0]   last_q, last_d;
    logic [IDXW-1:0]   grant_q, grant_d;
    logic [3:0]        op_q, op_d;
    logic [XLEN-1:0]   a_q, a_d;
    logic [XLEN-1:0]   b_q, b_d;
    logic [XLEN-1:0]   data_q, data_d;
    logic              err_q, err_d;

    logic [NREQ-1:0]   pick_gnt;
    logic [IDXW-1:0]   pick_idx;
    logic              pick_any;
    logic [3:0]        sel_op;
    logic [XLEN-1:0]   sel_a;
    logic [XLEN-1:0]   sel_b;
    logic              issue_legal;
    logic              rsp_take;

    alu_share_arb_rr_pick #(
        .NREQ (NREQ),
        .IDXW (IDXW)
    ) u_pick (
        .req  (req_valid),
        .last (last_q),
        .gnt  (pick_gnt),
        .idx  (pick_idx),
        .any  (pick_any)
    );

    // One-hot grant selects the winner's operands without a wide mux index.
    always_comb begin
        sel_op = '0;
        sel_a  = '0;
        sel_b  = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (pick_gnt[i]) begin
                sel_op = sel_op | req_op[4*i +: 4];
                sel_a  = sel_a  | req_a[XLEN*i +: XLEN];
                sel_b  = sel_b  | req_b[XLEN*i +: XLEN];
            end
        end
    end

    assign issue_legal = op_is_legal(op_q);
    assign rsp_take    = rsp_ready[grant_q];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (pick_any) state_d = ISSUE;
            ISSUE:   state_d = RESP;
            RESP:    if (rsp_take) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        req_ready = '0;
        rsp_valid = '0;
        alu_op    = ALU_ADD;
        alu_a     = '0;
        alu_b     = '0;
        busy      = (state_q != IDLE);
        if (state_q == IDLE && pick_any && !rst) begin
            req_ready = pick_gnt;
        end
        if (state_q == RESP) begin
            rsp_valid[grant_q] = 1'b1;
        end
        if (state_q == ISSUE && issue_legal) begin
            alu_op = op_q;
            alu_a  = a_q;
            alu_b  = b_q;
        end
    end

    always_comb begin
        last_d  = last_q;
        grant_d = grant_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        data_d  = data_q;
        err_d   = err_q;
        if (state_q == IDLE && pick_any) begin
            grant_d = pick_idx;
            op_d    = sel_op;
            a_d     = sel_a;
            b_d     = sel_b;
        end
        if (state_q == ISSUE) begin
            if (issue_legal) begin
                data_d = alu_result;
                err_d  = 1'b0;
            end else begin
                data_d = '0;
                err_d  = 1'b1;
            end
        end
        if (state_q == RESP && rsp_take) begin
            last_d = grant_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_q  <= IDXW'(NREQ - 1);
            grant_q <= '0;
            op_q    <= ALU_ADD;
            a_q     <= '0;
            b_q     <= '0;
            data_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            last_q  <= last_d;
            grant_q <= grant_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            data_q  <= data_d;
            err_q   <= err_d;
        end
    end

    assign rsp_data = data_q;
    assign rsp_err  = err_q;

endmodule

// File: tb/tb_alu_share_arb.sv
// Bench for alu_share_arb: directed scenarios plus randomized rounds
// checked against a round-robin/arithmetic reference model.
module tb_alu_share_arb;
    import alu_share_arb_pkg::*;

    localparam int NREQ = 2;
    localparam int XLEN = 32;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [NREQ-1:0]   req_valid = '0;
    logic [NREQ-1:0]   req_ready;
    logic [4*NREQ-1:0] req_op = '0;
    logic [XLEN*NREQ-1:0] req_a = '0;
    logic [XLEN*NREQ-1:0] req_b = '0;
    logic [NREQ-1:0]   rsp_valid;
    logic [NREQ-1:0]   rsp_ready = '0;
    logic [XLEN-1:0]   rsp_data;
    logic              rsp_err;
    logic [3:0]        alu_op;
    logic [XLEN-1:0]   alu_a;
    logic [XLEN-1:0]   alu_b;
    logic [XLEN-1:0]   alu_result;
    logic              busy;

    int n_cmp = 0;
    int n_bad = 0;
    int ref_last = NREQ - 1;
    int op_abort = 0;
    int idle_leak = 0;
    int illegal_leak = 0;
    logic illegal_active = 1'b0;

    alu_share_arb #(.NREQ(NREQ), .XLEN(XLEN)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_a      (req_a),
        .req_b      (req_b),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_data   (rsp_data),
        .rsp_err    (rsp_err),
        .alu_op     (alu_op),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_result (alu_result),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // Stand-in for the shared ALU.
    assign alu_result = alu_a + alu_b;

    always @(negedge clk) begin
        if (alu_op != ALU_ADD) op_abort++;
        if (!busy && (alu_a != 0 || alu_b != 0)) idle_leak++;
        if (illegal_active && (alu_a != 0 || alu_b != 0)) illegal_leak++;
    end

    function automatic int ref_pick(input logic [NREQ-1:0] v);
        int w;
        w = -1;
        for (int i = 1; i <= NREQ; i++) begin
            if (w < 0 && v[(ref_last + i) % NREQ]) w = (ref_last + i) % NREQ;
        end
        return w;
    endfunction

    function automatic logic [XLEN-1:0] ref_data(input logic [3:0] op,
                                                 input logic [XLEN-1:0] a,
                                                 input logic [XLEN-1:0] b);
        longint s;
        if (op != ALU_ADD) return '0;
        s = (longint'(a) + longint'(b)) % 64'sh1_0000_0000;
        return s[XLEN-1:0];
    endfunction

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b1;
        req_valid = '0;
        rsp_ready = '0;
        @(negedge clk);
        rst = 1'b0;
        ref_last = NREQ - 1;
    endtask

    // Drives one request round; called and returns in the low clock phase.
    task automatic do_round(input logic [1:0] v,
                            input logic [3:0] op0, input logic [3:0] op1,
                            input logic [31:0] a0, input logic [31:0] b0,
                            input logic [31:0] a1, input logic [31:0] b1,
                            input int hold,
                            output int g, output int lat,
                            output logic [31:0] d, output logic e,
                            output int glitches);
        logic [1:0] gm;
        g = -1;
        lat = -1;
        d = '0;
        e = 1'b0;
        glitches = 0;
        req_valid = v;
        req_op = {op1, op0};
        req_a = {a1, a0};
        req_b = {b1, b0};
        #1;
        for (int k = 0; k < 20 && req_ready == 0; k++) begin
            @(negedge clk);
            #1;
        end
        if (req_ready == 0) return;
        g = (req_ready == 2'b01) ? 0 : (req_ready == 2'b10) ? 1 : -2;
        if (g < 0) return;
        gm = 2'(1 << g);
        @(posedge clk);
        #1;
        req_valid[g] = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (rsp_valid != 0) begin
                lat = k;
                break;
            end
            if (req_ready != 0) glitches++;
        end
        if (lat < 0) return;
        if (rsp_valid != gm) glitches++;
        d = rsp_data;
        e = rsp_err;
        for (int k = 0; k < hold; k++) begin
            rsp_ready = ~gm;
            @(negedge clk);
            if (rsp_valid != gm || rsp_data !== d || rsp_err !== e ||
                req_ready != 0 || !busy) glitches++;
        end
        rsp_ready = gm;
        @(negedge clk);
        rsp_ready = '0;
        if (rsp_valid != 0 || busy) glitches++;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req_valid = 2'b11;
        @(negedge clk);
        @(negedge clk);
        n_cmp++;
        if (req_ready !== 2'b00) begin
            n_bad++;
            $display("FAIL reset_req_ready: got %b want 00", req_ready);
        end
        n_cmp++;
        if (rsp_valid !== 2'b00 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_valid_busy: got rsp_valid=%b busy=%b want 00/0",
                     rsp_valid, busy);
        end
        n_cmp++;
        if (rsp_data !== 32'h0 || rsp_err !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_rsp: got data=%h err=%b want 0/0", rsp_data, rsp_err);
        end
        n_cmp++;
        if (alu_op !== ALU_ADD || alu_a !== 32'h0 || alu_b !== 32'h0) begin
            n_bad++;
            $display("FAIL reset_alu: got op=%h a=%h b=%h want 0/0/0", alu_op, alu_a, alu_b);
        end
        req_valid = '0;
        rst = 1'b0;
        ref_last = NREQ - 1;
    endtask

    task automatic test_single();
        int g, lat, gl, ge;
        logic [31:0] d;
        logic e;
        ge = ref_pick(2'b01);
        do_round(2'b01, ALU_ADD, ALU_ADD, 32'd5, 32'd7, 32'd0, 32'd0, 0,
                 g, lat, d, e, gl);
        n_cmp++;
        if (g !== ge || lat !== 2) begin
            n_bad++;
            $display("FAIL single_grant_lat: got g=%0d lat=%0d want %0d/2", g, lat, ge);
        end
        n_cmp++;
        if (d !== 32'd12 || e !== 1'b0 || gl !== 0) begin
            n_bad++;
            $display("FAIL single_rsp: got data=%0d err=%b glitch=%0d want 12/0/0", d, e, gl);
        end
        ref_last = ge;
    endtask

    task automatic test_contention();
        int g, lat, gl, ge;
        logic [31:0] d;
        logic e;
        apply_reset();
        for (int t = 0; t < 4; t++) begin
            ge = ref_pick(2'b11);
            do_round(2'b11, ALU_ADD, ALU_ADD, 32'd1, 32'd1, 32'd1, 32'd1, 0,
                     g, lat, d, e, gl);
            n_cmp++;
            if (g !== ge || g !== t % 2 || d !== 32'd2 || e !== 1'b0 || gl !== 0) begin
                n_bad++;
                $display("FAIL contention_%0d: got g=%0d data=%0d err=%b glitch=%0d want %0d/2/0/0",
                         t, g, d, e, gl, ge);
            end
            ref_last = ge;
        end
    endtask

    task automatic test_illegal();
        int g, lat, gl, ge, ab0;
        logic [31:0] d;
        logic e;
        ab0 = op_abort;
        illegal_leak = 0;
        illegal_active = 1'b1;
        ge = ref_pick(2'b10);
        do_round(2'b10, ALU_ADD, 4'hF, 32'd0, 32'd0, 32'd3, 32'd4, 1,
                 g, lat, d, e, gl);
        illegal_active = 1'b0;
        n_cmp++;
        if (g !== ge || lat !== 2 || d !== 32'd0 || e !== 1'b1 || gl !== 0) begin
            n_bad++;
            $display("FAIL illegal_rsp: got g=%0d lat=%0d data=%h err=%b glitch=%0d want %0d/2/0/1/0",
                     g, lat, d, e, gl, ge);
        end
        n_cmp++;
        if (illegal_leak !== 0 || op_abort !== ab0) begin
            n_bad++;
            $display("FAIL illegal_alu_idle: got leak=%0d aborts=%0d want 0/%0d",
                     illegal_leak, op_abort, ab0);
        end
        ref_last = ge;
    endtask

    task automatic test_backpressure();
        int g, lat, gl, ge;
        logic [31:0] d;
        logic e;
        for (int t = 0; t < 2; t++) begin
            ge = ref_pick(2'b11);
            do_round(2'b11, ALU_ADD, ALU_ADD, 32'd100, 32'd23, 32'd40, 32'd2, 3,
                     g, lat, d, e, gl);
            n_cmp++;
            if (g !== ge || gl !== 0 ||
                d !== ref_data(ALU_ADD, ge == 0 ? 32'd100 : 32'd40,
                               ge == 0 ? 32'd23 : 32'd2)) begin
                n_bad++;
                $display("FAIL backpressure_%0d: got g=%0d data=%0d glitch=%0d want %0d/ok/0",
                         t, g, d, gl, ge);
            end
            ref_last = ge;
        end
    endtask

    task automatic test_wrap();
        int g, lat, gl, ge;
        logic [31:0] d;
        logic e;
        ge = ref_pick(2'b01);
        do_round(2'b01, ALU_ADD, ALU_ADD, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'd0, 0,
                 g, lat, d, e, gl);
        n_cmp++;
        if (g !== ge || d !== 32'h0 || e !== 1'b0 || gl !== 0) begin
            n_bad++;
            $display("FAIL wrap: got g=%0d data=%h err=%b glitch=%0d want %0d/0/0/0",
                     g, d, e, gl, ge);
        end
        ref_last = ge;
    endtask

    task automatic test_random();
        int g, lat, gl, ge, hold;
        logic [31:0] d, a0, b0, a1, b1, ea, eb;
        logic [3:0] op0, op1, eo;
        logic [1:0] v;
        logic e;
        for (int t = 0; t < 40; t++) begin
            v = 2'($urandom_range(1, 3));
            op0 = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(1, 15)) : ALU_ADD;
            op1 = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(1, 15)) : ALU_ADD;
            a0 = $urandom;
            b0 = $urandom;
            a1 = $urandom;
            b1 = $urandom;
            hold = $urandom_range(0, 3);
            ge = ref_pick(v);
            eo = (ge == 0) ? op0 : op1;
            ea = (ge == 0) ? a0 : a1;
            eb = (ge == 0) ? b0 : b1;
            do_round(v, op0, op1, a0, b0, a1, b1, hold, g, lat, d, e, gl);
            n_cmp++;
            if (g !== ge || lat !== 2 || d !== ref_data(eo, ea, eb) ||
                e !== (eo != ALU_ADD) || gl !== 0) begin
                n_bad++;
                $display("FAIL random_%0d: got g=%0d lat=%0d data=%h err=%b glitch=%0d want g=%0d data=%h err=%b",
                         t, g, lat, d, e, gl, ge, ref_data(eo, ea, eb), eo != ALU_ADD);
            end
            ref_last = ge;
        end
    endtask

    task automatic test_reset_in_resp();
        int g, lat, gl, ge;
        logic [31:0] d;
        logic e;
        apply_reset();
        ge = ref_pick(2'b01);
        do_round(2'b01, ALU_ADD, ALU_ADD, 32'd1, 32'd2, 32'd0, 32'd0, 0,
                 g, lat, d, e, gl);
        ref_last = ge;
        req_valid = 2'b10;
        req_op = {ALU_ADD, ALU_ADD};
        req_a = {32'd9, 32'd0};
        req_b = {32'd9, 32'd0};
        #1;
        for (int k = 0; k < 20 && req_ready == 0; k++) begin
            @(negedge clk);
            #1;
        end
        n_cmp++;
        if (req_ready !== 2'b10) begin
            n_bad++;
            $display("FAIL rir_accept: got %b want 10", req_ready);
        end
        @(posedge clk);
        #1;
        req_valid = '0;
        @(negedge clk);
        @(negedge clk);
        n_cmp++;
        if (rsp_valid !== 2'b10 || rsp_data !== 32'd18) begin
            n_bad++;
            $display("FAIL rir_pre: got rsp_valid=%b data=%0d want 10/18", rsp_valid, rsp_data);
        end
        #2;
        rst = 1'b1;
        #1;
        n_cmp++;
        if (rsp_valid !== 2'b00 || busy !== 1'b0 || rsp_data !== 32'h0) begin
            n_bad++;
            $display("FAIL rir_async: got rsp_valid=%b busy=%b data=%h want 00/0/0",
                     rsp_valid, busy, rsp_data);
        end
        @(negedge clk);
        rst = 1'b0;
        ref_last = NREQ - 1;
        ge = ref_pick(2'b11);
        do_round(2'b11, ALU_ADD, ALU_ADD, 32'd4, 32'd4, 32'd6, 32'd6, 0,
                 g, lat, d, e, gl);
        n_cmp++;
        if (g !== ge || d !== 32'd8 || gl !== 0) begin
            n_bad++;
            $display("FAIL rir_after: got g=%0d data=%0d glitch=%0d want %0d/8/0", g, d, gl, ge);
        end
        ref_last = ge;
    endtask

    task automatic test_alu_idle();
        req_valid = '0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if (op_abort !== 0 || idle_leak !== 0) begin
            n_bad++;
            $display("FAIL alu_idle: got aborts=%0d idle_leak=%0d want 0/0", op_abort, idle_leak);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_contention();
        test_illegal();
        test_backpressure();
        test_wrap();
        test_random();
        test_reset_in_resp();
        test_alu_idle();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
